instr_encoder: RTL

// Packs RISC-V instruction fields (format, opcode, registers, functs, immediate) into a 32-bit
// RV32 instruction word. This is the inverse of the decode classification. The block is used by
// the self-test program generator and the boot-ROM builder to emit instruction streams into

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_enc_fifo.sv | 43 ++++
 rtl/instr_encoder.sv | 91 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// RV32 instruction format/opcode definitions shared by the encoder and the decoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Class reported for opcodes outside the supported set; never equals a legal fmt_e.
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic [2:0] fmt_of_opcode(input logic [4:0] op5);
    logic [2:0] f;
    f = FMT_NONE;
    case (op5)
      OPC_OP[6:2]:                    f = FMT_R;
      OPC_OP_IMM[6:2], OPC_LOAD[6:2],
      OPC_JALR[6:2], OPC_SYSTEM[6:2]: f = FMT_I;
      OPC_STORE[6:2]:                 f = FMT_S;
      OPC_BRANCH[6:2]:                f = FMT_B;
      OPC_LUI[6:2], OPC_AUIPC[6:2]:   f = FMT_U;
      OPC_JAL[6:2]:                   f = FMT_J;
      default:                        f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake and encoded-word output handshake of the instruction encoder.
interface instr_encoder_if;
  logic               in_valid;
  logic               in_ready;
  riscv_pkg::fmt_e    fmt;
  logic [6:0]         opcode;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [31:0]        imm;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_instr;
  logic               out_err;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/instr_enc_fifo.sv
// Two-entry FIFO holding {err, instr}; the caller never pushes when full or pops when empty.
module instr_enc_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
endmodule

// File: rtl/instr_encoder.sv
// Packs RV32 instruction fields into a 32-bit word, flags illegal bundles and buffers
// results in a 2-deep queue with saturating good/error beat counters.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter bit STRICT = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  logic [31:0] imm;
  logic [31:0] word;
  logic        bad_imm;
  logic        err;
  logic        accept;
  logic        pop;
  logic        full;
  logic        empty;
  logic [32:0] head;

  assign imm = bus.imm;

  always_comb begin
    word    = '0;
    bad_imm = 1'b0;
    case (bus.fmt)
      FMT_R: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I: begin
        word    = {imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        bad_imm = !(&imm[31:11] || ~|imm[31:11]);
      end
      FMT_S: begin
        word    = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], bus.opcode};
        bad_imm = !(&imm[31:11] || ~|imm[31:11]);
      end
      FMT_B: begin
        word    = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11],
                   bus.opcode};
        bad_imm = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
      end
      FMT_U: begin
        word    = {imm[31:12], bus.rd, bus.opcode};
        bad_imm = |imm[11:0];
      end
      FMT_J: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, bus.opcode};
        bad_imm = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
      end
      default: bad_imm = 1'b1;
    endcase
    err = bad_imm || (bus.opcode[1:0] != 2'b11) ||
          (STRICT && (fmt_of_opcode(bus.opcode[6:2]) != 3'(bus.fmt)));
  end

  assign accept = bus.in_valid && !full;
  assign pop    = !empty && bus.out_ready;

  instr_enc_fifo #(.W(33)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (err ? {1'b1, 32'h0} : {1'b0, word}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // Ready comes only from registered occupancy, so out_ready never reaches in_ready.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? 32'h0 : head[31:0];
  assign bus.out_err   = !empty && head[32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (accept) begin
      if (err) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
      end else begin
        if (enc_count != '1) enc_count <= enc_count + CNT_W'(1);
      end
    end
  end
endmodule
